// File: rtl/seg7_scan_driver.sv
//------------------------------------------------------------------------------
// Module   : seg7_scan_driver
// Purpose  : Latches a 16-bit hex value and scans it onto a 4-digit,
//            common-anode, multiplexed seven-segment display.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seg7_scan_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter int LZ_BLANK    = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_en,
  input  logic        enable,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame
);

  localparam int c_CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(REFRESH_DIV - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

  logic [c_CNT_W-1:0] r_cnt;
  logic [1:0]         r_idx;
  logic [15:0]        r_value_q;
  logic [3:0]         r_dp_q;
  logic [3:0]         r_an;
  logic [6:0]         r_seg;
  logic               r_dp;
  logic               r_frame;

  logic [3:0]         w_nibble;
  logic               w_lead_zero;
  logic               w_blank;
  logic               w_wrap;
  logic [6:0]         w_seg;
  logic [3:0]         w_an;
  logic               w_dp;

  assign w_wrap = (r_cnt == c_CNT_MAX);

  always_comb begin
    w_nibble    = r_value_q[3:0];
    w_lead_zero = 1'b0;
    case (r_idx)
      2'd0: begin
        w_nibble    = r_value_q[3:0];
        w_lead_zero = 1'b0;
      end
      2'd1: begin
        w_nibble    = r_value_q[7:4];
        w_lead_zero = ~|r_value_q[15:4];
      end
      2'd2: begin
        w_nibble    = r_value_q[11:8];
        w_lead_zero = ~|r_value_q[15:8];
      end
      default: begin
        w_nibble    = r_value_q[15:12];
        w_lead_zero = ~|r_value_q[15:12];
      end
    endcase
  end

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  always_comb begin
    w_seg = 7'h7F;
    case (w_nibble)
      4'h0: w_seg = 7'h40;
      4'h1: w_seg = 7'h79;
      4'h2: w_seg = 7'h24;
      4'h3: w_seg = 7'h30;
      4'h4: w_seg = 7'h19;
      4'h5: w_seg = 7'h12;
      4'h6: w_seg = 7'h02;
      4'h7: w_seg = 7'h78;
      4'h8: w_seg = 7'h00;
      4'h9: w_seg = 7'h10;
      4'hA: w_seg = 7'h08;
      4'hB: w_seg = 7'h03;
      4'hC: w_seg = 7'h46;
      4'hD: w_seg = 7'h21;
      4'hE: w_seg = 7'h06;
      default: w_seg = 7'h0E;
    endcase
  end

  always_comb begin
    w_blank = !enable || ((LZ_BLANK != 0) && w_lead_zero);
    w_an    = ~(4'b0001 << r_idx);
    w_dp    = ~r_dp_q[r_idx];
    if (w_blank) begin
      w_an = 4'hF;
      w_dp = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt     <= '0;
      r_idx     <= 2'd0;
      r_value_q <= 16'h0000;
      r_dp_q    <= 4'h0;
      r_an      <= 4'hF;
      r_seg     <= 7'h7F;
      r_dp      <= 1'b1;
      r_frame   <= 1'b0;
    end else begin
      if (load) begin
        r_value_q <= value;
        r_dp_q    <= dp_en;
      end
      if (w_wrap) begin
        r_cnt <= '0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_cnt <= r_cnt + c_CNT_ONE;
      end
      r_frame <= w_wrap && (r_idx == 2'd3);
      r_an    <= w_an;
      r_seg   <= w_blank ? 7'h7F : w_seg;
      r_dp    <= w_dp;
    end
  end

  assign an    = r_an;
  assign seg   = r_seg;
  assign dp    = r_dp;
  assign frame = r_frame;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
//------------------------------------------------------------------------------
// Module   : tb_seg7_scan_driver
// Purpose  : Directed self-checking bench for seg7_scan_driver (three configs).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_en;
  logic        enable;

  logic [3:0] an_a, an_b, an_c;
  logic [6:0] seg_a, seg_b, seg_c;
  logic       dp_a, dp_b, dp_c;
  logic       frame_a, frame_b, frame_c;

  int n_assert = 0;
  int n_fail   = 0;
  int e        = 0;

  always #5 clk = ~clk;

  // a: blanking on, b: blanking off, c: one cycle per digit
  seg7_scan_driver #(.REFRESH_DIV(4), .LZ_BLANK(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .load(load), .value(value), .dp_en(dp_en),
    .enable(enable), .an(an_a), .seg(seg_a), .dp(dp_a), .frame(frame_a));

  seg7_scan_driver #(.REFRESH_DIV(4), .LZ_BLANK(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .load(load), .value(value), .dp_en(dp_en),
    .enable(enable), .an(an_b), .seg(seg_b), .dp(dp_b), .frame(frame_b));

  seg7_scan_driver #(.REFRESH_DIV(1), .LZ_BLANK(1)) dut_c (
    .clk(clk), .reset_n(reset_n), .load(load), .value(value), .dp_en(dp_en),
    .enable(enable), .an(an_c), .seg(seg_c), .dp(dp_c), .frame(frame_c));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    e++;
    chk("onehot_a", 16'($countones(~an_a) <= 1), 16'd1);
    chk("onehot_b", 16'($countones(~an_b) <= 1), 16'd1);
    chk("onehot_c", 16'($countones(~an_c) <= 1), 16'd1);
  endtask

  task automatic run_to(input int n);
    while (e < n) tick();
  endtask

  initial begin
    reset_n = 1'b0; load = 1'b0; value = 16'h0000; dp_en = 4'h0; enable = 1'b1;

    // Reset held for three edges
    repeat (3) tick();
    chk("rst_an",    16'(an_a),    16'hF);
    chk("rst_seg",   16'(seg_a),   16'h7F);
    chk("rst_dp",    16'(dp_a),    16'h1);
    chk("rst_frame", 16'(frame_a), 16'h0);
    chk("rst_an_c",  16'(an_c),    16'hF);
    reset_n = 1'b1;
    e = 0;

    // Scan of an all-zero value
    run_to(1);
    chk("p1_an",    16'(an_a),  16'hE);
    chk("p1_seg",   16'(seg_a), 16'h40);
    chk("p1_dp",    16'(dp_a),  16'h1);
    chk("p1_anb",   16'(an_b),  16'hE);
    run_to(4);
    chk("p1_an_e4", 16'(an_a),  16'hE);
    run_to(5);
    chk("p1_lz1_an",  16'(an_a),  16'hF);
    chk("p1_lz1_seg", 16'(seg_a), 16'h7F);
    chk("p1_nlz1_an", 16'(an_b),  16'hD);
    chk("p1_nlz1_seg",16'(seg_b), 16'h40);
    run_to(9);
    chk("p1_nlz2_an", 16'(an_b),  16'hB);
    run_to(13);
    chk("p1_nlz3_an", 16'(an_b),  16'h7);
    chk("p1_lz3_an",  16'(an_a),  16'hF);
    run_to(15);
    chk("p1_frame_pre", 16'(frame_a), 16'h0);
    run_to(16);
    chk("p1_frame",   16'(frame_a), 16'h1);
    chk("p1_frame_b", 16'(frame_b), 16'h1);
    run_to(17);
    chk("p1_frame_end", 16'(frame_a), 16'h0);
    chk("p1_wrap_an",   16'(an_a),    16'hE);

    // Full value 1A2F with dp on digit 2, captured at edge 18
    load = 1'b1; value = 16'h1A2F; dp_en = 4'b0100;
    run_to(18);
    load = 1'b0;
    chk("p2_hold_seg", 16'(seg_a), 16'h40);
    run_to(19);
    chk("p2_d0_seg", 16'(seg_a), 16'h0E);
    chk("p2_d0_an",  16'(an_a),  16'hE);
    chk("p2_d0_dp",  16'(dp_a),  16'h1);
    chk("p2_c_an",   16'(an_c),  16'hB);
    chk("p2_c_seg",  16'(seg_c), 16'h08);
    chk("p2_c_dp",   16'(dp_c),  16'h0);
    run_to(20);
    chk("p2_c3_an",    16'(an_c),    16'h7);
    chk("p2_c3_seg",   16'(seg_c),   16'h79);
    chk("p2_c_frame",  16'(frame_c), 16'h1);
    run_to(21);
    chk("p2_d1_seg",   16'(seg_a),   16'h24);
    chk("p2_d1_an",    16'(an_a),    16'hD);
    chk("p2_d1_dp",    16'(dp_a),    16'h1);
    chk("p2_c0_an",    16'(an_c),    16'hE);
    chk("p2_c0_seg",   16'(seg_c),   16'h0E);
    chk("p2_c_frame0", 16'(frame_c), 16'h0);
    run_to(22);
    chk("p2_c1_an",    16'(an_c),    16'hD);
    run_to(24);
    chk("p2_c_frame2", 16'(frame_c), 16'h1);
    run_to(25);
    chk("p2_d2_seg", 16'(seg_a), 16'h08);
    chk("p2_d2_an",  16'(an_a),  16'hB);
    chk("p2_d2_dp",  16'(dp_a),  16'h0);
    run_to(29);
    chk("p2_d3_seg", 16'(seg_a), 16'h79);
    chk("p2_d3_an",  16'(an_a),  16'h7);
    chk("p2_d3_dp",  16'(dp_a),  16'h1);
    run_to(32);
    chk("p2_frame",  16'(frame_a), 16'h1);
    run_to(33);
    chk("p2_rep_d0", 16'(seg_a), 16'h0E);
    run_to(37);
    chk("p2_rep_d1_seg", 16'(seg_a), 16'h24);
    chk("p2_rep_d1_an",  16'(an_a),  16'hD);

    // Load 0099 while digit 1 is active, captured at edge 39
    run_to(38);
    load = 1'b1; value = 16'h0099; dp_en = 4'h0;
    run_to(39);
    load = 1'b0;
    chk("p3_k_an",   16'(an_a),  16'hD);
    chk("p3_k_seg",  16'(seg_a), 16'h24);
    run_to(40);
    chk("p3_k1_an",  16'(an_a),  16'hD);
    chk("p3_k1_seg", 16'(seg_a), 16'h10);
    run_to(41);
    chk("p3_d2_an",  16'(an_a),  16'hF);
    chk("p3_d2_seg", 16'(seg_a), 16'h7F);
    run_to(48);
    chk("p3_frame",  16'(frame_a), 16'h1);
    run_to(49);
    chk("p3_d0_seg", 16'(seg_a), 16'h10);

    // Leading-zero blanking overrides a decimal-point request
    load = 1'b1; value = 16'h0050; dp_en = 4'b1000;
    run_to(50);
    load = 1'b0;
    run_to(51);
    chk("p4_d0_seg", 16'(seg_a), 16'h40);
    chk("p4_d0_an",  16'(an_a),  16'hE);
    run_to(53);
    chk("p4_d1_seg", 16'(seg_a), 16'h12);
    chk("p4_d1_an",  16'(an_a),  16'hD);
    run_to(57);
    chk("p4_d2_an",   16'(an_a),  16'hF);
    chk("p4_d2_dp",   16'(dp_a),  16'h1);
    chk("p4_d2_anb",  16'(an_b),  16'hB);
    chk("p4_d2_segb", 16'(seg_b), 16'h40);
    run_to(61);
    chk("p4_d3_an",   16'(an_a),  16'hF);
    chk("p4_d3_seg",  16'(seg_a), 16'h7F);
    chk("p4_d3_dp",   16'(dp_a),  16'h1);
    chk("p4_d3_anb",  16'(an_b),  16'h7);
    chk("p4_d3_segb", 16'(seg_b), 16'h40);
    chk("p4_d3_dpb",  16'(dp_b),  16'h0);

    // Display disabled for ten edges while scanning continues
    run_to(65);
    enable = 1'b0;
    run_to(66);
    chk("p5_off_an",   16'(an_a),  16'hF);
    chk("p5_off_seg",  16'(seg_a), 16'h7F);
    chk("p5_off_anb",  16'(an_b),  16'hF);
    chk("p5_off_segb", 16'(seg_b), 16'h7F);
    chk("p5_off_dpb",  16'(dp_b),  16'h1);
    run_to(75);
    chk("p5_off_anb2", 16'(an_b),  16'hF);
    enable = 1'b1;
    run_to(76);
    chk("p5_on_anb",  16'(an_b),  16'hB);
    chk("p5_on_segb", 16'(seg_b), 16'h40);
    run_to(77);
    chk("p5_on3_anb", 16'(an_b),  16'h7);
    chk("p5_on3_dpb", 16'(dp_b),  16'h0);
    run_to(80);
    chk("p5_frame",   16'(frame_a), 16'h1);
    run_to(81);
    chk("p5_d0_an",   16'(an_a),  16'hE);

    // Reset in the same cycle as a load; reset must win
    reset_n = 1'b0; load = 1'b1; value = 16'hFFFF; dp_en = 4'hF;
    run_to(82);
    chk("p6_rst_an",    16'(an_a),    16'hF);
    chk("p6_rst_seg",   16'(seg_a),   16'h7F);
    chk("p6_rst_dp",    16'(dp_a),    16'h1);
    chk("p6_rst_frame", 16'(frame_a), 16'h0);
    reset_n = 1'b1; load = 1'b0;
    run_to(83);
    chk("p6_d0_an",  16'(an_a),  16'hE);
    chk("p6_d0_seg", 16'(seg_a), 16'h40);
    chk("p6_d0_dp",  16'(dp_a),  16'h1);
    run_to(86);
    chk("p6_full_anb", 16'(an_b), 16'hE);
    run_to(87);
    chk("p6_next_anb", 16'(an_b), 16'hD);
    chk("p6_next_an",  16'(an_a), 16'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
